// File: rtl/dds_spi_loader.sv
// -----------------------------------------------------------------------------
// dds_spi_loader
//
// Purpose:
//   Receives 16-bit words over a 3-wire serial link (sclk / fsync / sdata,
//   all asynchronous to clock). It decodes each word into DDS frequency and
//   phase tuning registers and control bits. Words are MSB first. A bit is
//   taken on each falling sclk edge while fsync is low. Frequency words can be
//   written by 14-bit halves (b28=0). They can also be written as two
//   consecutive 14-bit writes that update all 28 bits at once (b28=1).
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low
//   sclk         in   serial clock (async, idles high), up to clock/4
//   fsync        in   frame select, active-low (async)
//   sdata        in   serial data, MSB first (async)
//   freq0_set    out  [27:0] frequency tuning word 0
//   freq1_set    out  [27:0] frequency tuning word 1
//   phase0_set   out  [11:0] phase offset 0
//   phase1_set   out  [11:0] phase offset 1
//   freq_sel     out  selects freq1_set when 1
//   phase_sel    out  selects phase1_set when 1
//   dds_reset    out  active-high accumulator clear
//   word_valid   out  one-cycle pulse per accepted word
//   abort_count  out  [7:0] saturating count of aborted partial words
//                     (present only when DDS_SPI_ABORTCNT_EN is defined)
//
// Build option:
//   DDS_SPI_ABORTCNT_EN - adds the abort counter and its abort_count port.
// -----------------------------------------------------------------------------
module dds_spi_loader (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        fsync,
    input  logic        sdata,
    output logic [27:0] freq0_set,
    output logic [27:0] freq1_set,
    output logic [11:0] phase0_set,
    output logic [11:0] phase1_set,
    output logic        freq_sel,
    output logic        phase_sel,
    output logic        dds_reset,
    output logic        word_valid
`ifdef DDS_SPI_ABORTCNT_EN
    ,
    output logic [7:0]  abort_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (2 flops each) plus one history flop for edge
    // detection on sclk and fsync.
    // ------------------------------------------------------------------
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_fsync_meta, r_fsync_sync, r_fsync_prev;
    logic r_sdata_meta, r_sdata_sync;

    // The fsync chain resets to 0 (active) rather than to its idle level.
    // If the pins are already mid-frame when reset releases, the chain
    // therefore never sees a falling edge. The frame is ignored until fsync
    // goes high and then falls again.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sclk_meta  <= 1'b1;
            r_sclk_sync  <= 1'b1;
            r_sclk_prev  <= 1'b1;
            r_fsync_meta <= 1'b0;
            r_fsync_sync <= 1'b0;
            r_fsync_prev <= 1'b0;
            r_sdata_meta <= 1'b0;
            r_sdata_sync <= 1'b0;
        end else begin
            r_sclk_meta  <= sclk;
            r_sclk_sync  <= r_sclk_meta;
            r_sclk_prev  <= r_sclk_sync;
            r_fsync_meta <= fsync;
            r_fsync_sync <= r_fsync_meta;
            r_fsync_prev <= r_fsync_sync;
            r_sdata_meta <= sdata;
            r_sdata_sync <= r_sdata_meta;
        end
    end

    logic w_sclk_fall;
    logic w_fsync_fall;
    assign w_sclk_fall  = r_sclk_prev & ~r_sclk_sync;
    assign w_fsync_fall = r_fsync_prev & ~r_fsync_sync;

    // ------------------------------------------------------------------
    // Receive FSM, shift register and register file
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [14:0] r_shift;      // first 15 bits of the word, MSB first
    logic [27:0] r_freq0, r_freq1;
    logic [11:0] r_phase0, r_phase1;
    logic        r_freq_sel, r_phase_sel, r_dds_reset, r_word_valid;
    logic        r_b28, r_hlb, r_pending, r_stage_tgt;
    logic [13:0] r_stage;
`ifdef DDS_SPI_ABORTCNT_EN
    logic [7:0]  r_abort_cnt;
`endif

    // Fields of the word completed by the bit arriving this cycle.
    // W[15:13] comes from the shift register; W[13:0] is the payload.
    logic [2:0]  w_wtop;
    logic [13:0] w_d;
    assign w_wtop = r_shift[14:12];
    assign w_d    = {r_shift[12:0], r_sdata_sync};

    // Frequency target: W[15]=0 -> freq0, W[15]=1 -> freq1.
    logic w_tgt;
    assign w_tgt = w_wtop[2];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 15'd0;
            r_freq0      <= 28'd0;
            r_freq1      <= 28'd0;
            r_phase0     <= 12'd0;
            r_phase1     <= 12'd0;
            r_freq_sel   <= 1'b0;
            r_phase_sel  <= 1'b0;
            r_dds_reset  <= 1'b1;
            r_word_valid <= 1'b0;
            r_b28        <= 1'b0;
            r_hlb        <= 1'b0;
            r_pending    <= 1'b0;
            r_stage_tgt  <= 1'b0;
            r_stage      <= 14'd0;
`ifdef DDS_SPI_ABORTCNT_EN
            r_abort_cnt  <= 8'd0;
`endif
        end else begin
            r_word_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= 4'd0;
                    if (w_fsync_fall) begin
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (r_fsync_sync) begin
                        // fsync rose mid-word: drop the partial word. A rise
                        // with no bits taken is just the normal end of a
                        // multi-word frame and does not count as an abort.
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= 4'd0;
`ifdef DDS_SPI_ABORTCNT_EN
                        if (r_bit_cnt != 4'd0 && r_abort_cnt != 8'hFF) begin
                            r_abort_cnt <= r_abort_cnt + 8'd1;
                        end
`endif
                    end else if (w_sclk_fall) begin
                        r_shift   <= {r_shift[13:0], r_sdata_sync};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) begin
                            // 16th bit: decode now so the updated registers
                            // and the word_valid pulse appear during DONE.
                            r_state      <= ST_DONE;
                            r_word_valid <= 1'b1;
                            case (w_wtop[2:1])
                                2'b00: begin
                                    r_b28       <= r_shift[12];
                                    r_hlb       <= r_shift[11];
                                    r_freq_sel  <= r_shift[10];
                                    r_phase_sel <= r_shift[9];
                                    r_dds_reset <= r_shift[7];
                                    r_pending   <= 1'b0;
                                end
                                2'b01, 2'b10: begin
                                    if (!r_b28) begin
                                        if (w_tgt) begin
                                            if (r_hlb) r_freq1[27:14] <= w_d;
                                            else       r_freq1[13:0]  <= w_d;
                                        end else begin
                                            if (r_hlb) r_freq0[27:14] <= w_d;
                                            else       r_freq0[13:0]  <= w_d;
                                        end
                                    end else if (!r_pending || (r_stage_tgt != w_tgt)) begin
                                        // First half, or a target switch that
                                        // restarts the pair with a new LSB.
                                        r_stage     <= w_d;
                                        r_stage_tgt <= w_tgt;
                                        r_pending   <= 1'b1;
                                    end else begin
                                        if (w_tgt) r_freq1 <= {w_d, r_stage};
                                        else       r_freq0 <= {w_d, r_stage};
                                        r_pending <= 1'b0;
                                    end
                                end
                                default: begin
                                    if (w_wtop[0]) r_phase1 <= w_d[11:0];
                                    else           r_phase0 <= w_d[11:0];
                                end
                            endcase
                        end
                    end
                end

                ST_DONE: begin
                    r_bit_cnt <= 4'd0;
                    r_state   <= r_fsync_sync ? ST_IDLE : ST_SHIFT;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign freq0_set  = r_freq0;
    assign freq1_set  = r_freq1;
    assign phase0_set = r_phase0;
    assign phase1_set = r_phase1;
    assign freq_sel   = r_freq_sel;
    assign phase_sel  = r_phase_sel;
    assign dds_reset  = r_dds_reset;
    assign word_valid = r_word_valid;
`ifdef DDS_SPI_ABORTCNT_EN
    assign abort_count = r_abort_cnt;
`endif

endmodule

// File: tb/tb_dds_spi_loader.sv
// -----------------------------------------------------------------------------
// tb_dds_spi_loader
//
// Purpose:
//   Self-checking bench for dds_spi_loader. The bench drives directed serial
//   frames and then random ones. It compares every output against a
//   word-level reference model. It also compares word_valid pulse counts
//   against the number of words the model accepted.
//
// Ports: none (top-level bench).
// Build option: DDS_SPI_ABORTCNT_EN also enables the abort_count checks.
// -----------------------------------------------------------------------------
module tb_dds_spi_loader;

    logic        clk;
    logic        rst_n;
    logic        sclk, fsync, sdata;
    logic [27:0] freq0_set, freq1_set;
    logic [11:0] phase0_set, phase1_set;
    logic        freq_sel, phase_sel, dds_reset, word_valid;
`ifdef DDS_SPI_ABORTCNT_EN
    logic [7:0]  abort_count;
`endif

    dds_spi_loader dut (
        .clock      (clk),
        .reset      (rst_n),
        .sclk       (sclk),
        .fsync      (fsync),
        .sdata      (sdata),
        .freq0_set  (freq0_set),
        .freq1_set  (freq1_set),
        .phase0_set (phase0_set),
        .phase1_set (phase1_set),
        .freq_sel   (freq_sel),
        .phase_sel  (phase_sel),
        .dds_reset  (dds_reset),
        .word_valid (word_valid)
`ifdef DDS_SPI_ABORTCNT_EN
        ,
        .abort_count(abort_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- word_valid monitor (sampled on falling edge) --------
    int wv_high_cycles = 0;
    int wv_pulses      = 0;
    logic wv_last      = 1'b0;
    always @(negedge clk) begin
        if (word_valid) wv_high_cycles++;
        if (word_valid && !wv_last) wv_pulses++;
        wv_last = word_valid;
    end

    // ---------------- reference model (word level) -----------------------
    int unsigned m_freq[2];
    int unsigned m_phase[2];
    int unsigned m_fsel, m_psel, m_drst;
    int unsigned m_b28, m_hlb, m_pend, m_stage, m_stage_t;
    int unsigned m_words;
    int unsigned m_aborts;

    function automatic void model_reset();
        m_freq[0] = 0; m_freq[1] = 0; m_phase[0] = 0; m_phase[1] = 0;
        m_fsel = 0; m_psel = 0; m_drst = 1;
        m_b28 = 0; m_hlb = 0; m_pend = 0; m_stage = 0; m_stage_t = 0;
        m_aborts = 0;
    endfunction

    function automatic void model_word(input int unsigned w);
        int unsigned op, d, t;
        op = (w / 16384) % 4;
        d  = w % 16384;
        m_words++;
        if (op == 0) begin
            m_b28  = (w / 8192) % 2;
            m_hlb  = (w / 4096) % 2;
            m_fsel = (w / 2048) % 2;
            m_psel = (w / 1024) % 2;
            m_drst = (w / 256) % 2;
            m_pend = 0;
        end else if (op == 3) begin
            m_phase[(w / 8192) % 2] = w % 4096;
        end else begin
            t = (op == 2) ? 1 : 0;
            if (m_b28 == 0) begin
                if (m_hlb == 1) m_freq[t] = (m_freq[t] % 16384) + d * 16384;
                else            m_freq[t] = m_freq[t] - (m_freq[t] % 16384) + d;
            end else if (m_pend == 1 && m_stage_t == t) begin
                m_freq[t] = d * 16384 + m_stage;
                m_pend = 0;
            end else begin
                m_stage = d; m_stage_t = t; m_pend = 1;
            end
        end
    endfunction

    // ---------------- checking ------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_freq0"},  32'(freq0_set),  m_freq[0]);
        chk({tag, "_freq1"},  32'(freq1_set),  m_freq[1]);
        chk({tag, "_phase0"}, 32'(phase0_set), m_phase[0]);
        chk({tag, "_phase1"}, 32'(phase1_set), m_phase[1]);
        chk({tag, "_fsel"},   32'(freq_sel),   m_fsel);
        chk({tag, "_psel"},   32'(phase_sel),  m_psel);
        chk({tag, "_drst"},   32'(dds_reset),  m_drst);
        chk({tag, "_wv_pulses"}, 32'(wv_pulses),      m_words);
        chk({tag, "_wv_cycles"}, 32'(wv_high_cycles), m_words);
`ifdef DDS_SPI_ABORTCNT_EN
        chk({tag, "_abort"}, 32'(abort_count), (m_aborts > 255) ? 255 : m_aborts);
`endif
    endtask

    // ---------------- serial drivers (all steps on falling clock edges) ---
    task automatic send_bit(input logic b);
        sdata = b;
        #40 sclk = 1'b0;
        #40 sclk = 1'b1;
    endtask

    task automatic frame_begin();
        fsync = 1'b0;
        #60;
    endtask

    task automatic frame_end();
        #40 fsync = 1'b1;
        #80;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        #40;
    endtask

    // A one-word frame, reported as one transaction.
    task automatic xfer(input logic [15:0] w);
        frame_begin();
        send_word(w);
        frame_end();
        model_word(32'(w));
        $display("xfer word=0x%04h", w);
    endtask

    task automatic abort_frame(input int nbits);
        frame_begin();
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
        frame_end();
        m_aborts++;
        $display("abort after %0d bits", nbits);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 3))
            0: w[15:14] = 2'b00;
            1: w[15:14] = 2'b01;
            2: w[15:14] = 2'b10;
            default: w[15:14] = 2'b11;
        endcase
        return w;
    endfunction

    // ---------------- stimulus ------------------------------------------
    int base_wv;
    logic [15:0] q_words[$];

    initial begin
        rst_n = 1'b0; sclk = 1'b1; fsync = 1'b1; sdata = 1'b0;
        m_words = 0;
        model_reset();
        #40 rst_n = 1'b1;
        #40;
        check_all("reset");

        // Control 0x2000 (b28=1, dds_reset=0), then a paired freq0 write.
        xfer(16'h2000);
        chk("s1_drst", 32'(dds_reset), 0);
        base_wv = wv_pulses;
        xfer(16'h4001);
        chk("s1_freq0_first", 32'(freq0_set), 0);
        xfer(16'h4002);
        chk("s1_freq0_second", 32'(freq0_set), 32'h0008001);
        chk("s1_two_pulses", 32'(wv_pulses - base_wv), 2);
        check_all("s1");

        // Half-word write of freq1 MSBs.
        xfer(16'h1000);
        xfer(16'h8FFF);
        chk("s2_freq1", 32'(freq1_set), 32'h3FFC000);
        check_all("s2");

        // Phase write, then select bits.
        xfer(16'hE123);
        chk("s3_phase1", 32'(phase1_set), 32'h123);
        xfer(16'h0C00);
        chk("s3_fsel", 32'(freq_sel), 1);
        chk("s3_psel", 32'(phase_sel), 1);
        check_all("s3");

        // Abort after 9 bits.
        base_wv = wv_pulses;
        abort_frame(9);
        chk("s4_no_pulse", 32'(wv_pulses - base_wv), 0);
`ifdef DDS_SPI_ABORTCNT_EN
        chk("s4_abort_count", 32'(abort_count), 1);
`endif
        check_all("s4");

        // Target switch while pending, all words in one frame.
        xfer(16'h2000);
        frame_begin();
        send_word(16'h4001); model_word(32'h4001);
        send_word(16'h8002); model_word(32'h8002);
        chk("s5_freq0_kept", 32'(freq0_set), 32'h0008001);
        send_word(16'h8003); model_word(32'h8003);
        frame_end();
        $display("xfer frame words=0x4001,0x8002,0x8003");
        chk("s5_freq1", 32'(freq1_set), 32'h000C002);
        check_all("s5");

        // Reset after bit 8; the rest of that frame must be ignored.
        frame_begin();
        for (int i = 15; i >= 8; i--) send_bit(1'(16'h0A5A >> i));
        rst_n = 1'b0;
        #40 rst_n = 1'b1;
        #20;
        model_reset();
        base_wv = wv_pulses;
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        send_word(16'h0000);          // full word still inside the old frame
        frame_end();
        $display("reset mid-frame");
        chk("s6_no_word", 32'(wv_pulses - base_wv), 0);
        check_all("s6");
        xfer(16'h0000);
        chk("s6_accepted_drst", 32'(dds_reset), 0);
        check_all("s6b");

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k == 8) begin
                abort_frame($urandom_range(1, 15));
            end else if (k == 9) begin
                q_words.delete();
                for (int j = 0; j < $urandom_range(2, 3); j++) q_words.push_back(rand_word());
                frame_begin();
                foreach (q_words[j]) begin
                    send_word(q_words[j]);
                    model_word(32'(q_words[j]));
                end
                frame_end();
                $display("xfer frame of %0d words", q_words.size());
            end else begin
                xfer(rand_word());
            end
            check_all($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
